sa_feeder: RTL

Input sequencer at the top/left edge of the N×N bf16 systolic array.
- Collects one tile of weights and shifts it down the PE columns while the array is in load mode (mode 0).
- Switches the array to compute mode (mode 1).
- Streams activation vectors into the PE rows with a diagonal skew of one cycle per row, plus a per-row valid side-band.
- Drains the skew, signals tile completion and returns to weight collection.

---
 rtl/sa_pkg.sv | 24 ++
 rtl/sa_skew_delay.sv | 46 ++++
 rtl/sa_feeder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array edge feeder.
//
// Contents:
//   MUL_BW     - bf16 operand width carried on the left (row) edge
//   ADD_BW     - width of the PE vertical bus (psum / weight path)
//   DEF_N      - default array dimension
//   DEF_TAIL   - default number of extra compute-mode cycles after the skew drains
//   sa_state_e - feeder sequencing states, in tile order

package sa_pkg;

  localparam int MUL_BW   = 16;
  localparam int ADD_BW   = 32;
  localparam int DEF_N    = 4;
  localparam int DEF_TAIL = 8;

  typedef enum logic [1:0] {
    W_COLLECT = 2'd0,
    W_SHIFT   = 2'd1,
    STREAM    = 2'd2,
    DRAIN     = 2'd3
  } sa_state_e;

endpackage

// File: rtl/sa_skew_delay.sv
// Fixed-length register line carrying a data word and its valid bit together.
// One instance per array row produces the diagonal skew on the left edge.
//
// Parameters:
//   DEPTH - number of register stages (>= 1)
//   W     - data width
// Ports:
//   clk, rst - clock, synchronous active-high reset (clears every stage)
//   d_i, v_i - data / valid entering stage 0
//   d_o, v_o - data / valid leaving the last stage

module sa_skew_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  input  logic         v_i,
  output logic [W-1:0] d_o,
  output logic         v_o
);

  logic [W-1:0]     data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      data_q[0]  <= d_i;
      valid_q[0] <= v_i;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign d_o = data_q[DEPTH-1];
  assign v_o = valid_q[DEPTH-1];

endmodule

// File: rtl/sa_feeder.sv
// Input sequencer for the top/left edge of an N x N bf16 systolic array.
// A tile runs: collect N weight rows -> shift them down the PE columns in
// load mode -> stream activation vectors (diagonally skewed) in compute mode
// -> drain the skew plus TAIL cycles -> pulse o_done -> collect again.
//
// Handshakes: a beat transfers on a rising clock edge where both valid and
// ready are high. Ready never depends on valid; valid is ignored whenever
// ready is low, and data is only sampled on a transfer.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   w_valid/w_ready   - weight row handshake, w_data = one row (col c at c*MUL_BW)
//   a_valid/a_ready   - activation handshake, a_data element r feeds row r,
//                       a_last marks the final vector of the tile
//   o_mode            - PE mode broadcast (0 = weight load, 1 = compute)
//   o_top             - top-row PE vertical inputs (col c at c*ADD_BW)
//   o_left            - left-column PE inputs (row r at r*MUL_BW), skewed
//   o_left_valid      - per-row valid travelling with o_left
//   o_done            - one-cycle tile-complete pulse
//   dbg_state_o       - current sequencing state (sa_state_e encoding)

module sa_feeder
  import sa_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int TAIL = DEF_TAIL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [N*MUL_BW-1:0] w_data,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [N*MUL_BW-1:0] a_data,
  input  logic                a_last,
  output logic                o_mode,
  output logic [N*ADD_BW-1:0] o_top,
  output logic [N*MUL_BW-1:0] o_left,
  output logic [N-1:0]        o_left_valid,
  output logic                o_done,
  output logic [1:0]          dbg_state_o
);

  // One counter serves beat index, shift index and drain length.
  localparam int CW = $clog2(N + TAIL + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BEAT  = CW'(N - 1);
  localparam logic [CW-1:0] LAST_DRAIN = CW'(N + TAIL - 1);

  sa_state_e           state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N*MUL_BW-1:0] wbuf_q [N];
  logic [IW-1:0]       idx;
  logic                w_fire;
  logic                a_fire;

  assign idx = cnt_q[IW-1:0];

  // Outputs are forced low while rst is high so the array sees a quiet
  // edge even before the first reset edge has settled the state register.
  assign w_ready     = !rst && (state_q == W_COLLECT);
  assign a_ready     = !rst && (state_q == STREAM);
  assign o_mode      = !rst && ((state_q == STREAM) || (state_q == DRAIN));
  assign o_done      = !rst && (state_q == DRAIN) && (cnt_q == LAST_DRAIN);
  assign dbg_state_o = state_q;

  assign w_fire = w_valid && w_ready;
  assign a_fire = a_valid && a_ready;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      W_COLLECT: begin
        if (w_fire) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = W_SHIFT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      W_SHIFT: begin
        if (cnt_q == LAST_BEAT) begin
          state_d = STREAM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STREAM: begin
        cnt_d = '0;
        if (a_fire && a_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == LAST_DRAIN) begin
          state_d = W_COLLECT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = W_COLLECT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= W_COLLECT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Weight buffer holds data only; it needs no reset because it is only
  // read in W_SHIFT, after a full tile has been written.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      wbuf_q[idx] <= w_data;
    end
  end

  // Shift cycle k presents buffered row k. Row 0 is pushed first, so it
  // travels furthest and ends in the bottom PE row.
  always_comb begin
    o_top = '0;
    if (!rst && (state_q == W_SHIFT)) begin
      for (int c = 0; c < N; c++) begin
        o_top[c*ADD_BW +: MUL_BW] = wbuf_q[idx][c*MUL_BW +: MUL_BW];
      end
    end
  end

  // Row r is delayed r+1 cycles. Anything other than an accepted vector
  // (bubble, drain, weight phases) pushes zero data with valid low.
  for (genvar r = 0; r < N; r++) begin : g_row
    logic [MUL_BW-1:0] d_in;

    assign d_in = a_fire ? a_data[r*MUL_BW +: MUL_BW] : '0;

    sa_skew_delay #(
      .DEPTH (r + 1),
      .W     (MUL_BW)
    ) u_skew (
      .clk (clk),
      .rst (rst),
      .d_i (d_in),
      .v_i (a_fire),
      .d_o (o_left[r*MUL_BW +: MUL_BW]),
      .v_o (o_left_valid[r])
    );
  end

endmodule
